// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: requester A/B handshakes, clear control and
// the single-port memory interface. The slave modport is the arbiter's view;
// the master modport is the view of whatever surrounds it (requesters and
// the memory macro).
interface mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 14
);
    logic          en;
    logic          clr_start;
    logic          clr_busy;

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  en, clr_start,
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_dout,
        output clr_busy,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_cs, mem_we, mem_addr, mem_din
    );

    modport master (
        output en, clr_start,
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_dout,
        input  clr_busy,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between requester A (dsp
// engine) and requester B (pixel/config side). One access is issued per
// cycle, read data is routed back to its owner through a tag pipeline, and
// a clear sequencer can zero-fill the whole memory.
// RD_LAT (memory read latency) is legal in the range 1..3.
// Optional macro MEMARB_FIXED_PRIO_EN: A always wins contention instead of
// round-robin.
module mem_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 14,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            last_winner_q, last_winner_d;

    logic            mem_cs_q, mem_cs_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_din_q, mem_din_d;

    logic [RD_LAT:0] tag_valid_q, tag_valid_d;
    logic [RD_LAT:0] tag_owner_q, tag_owner_d;

    logic            a_rvalid_q, a_rvalid_d;
    logic [DW-1:0]   a_rdata_q, a_rdata_d;
    logic            b_rvalid_q, b_rvalid_d;
    logic [DW-1:0]   b_rdata_q, b_rdata_d;

    logic            a_gnt;
    logic            b_gnt;
    logic            clr_busy;
    logic            rd_push;

    // State register: FSM state and clear address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: enter CLEAR on a start pulse, walk the counter while enabled, leave after the last address.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (bus.en) begin
                    if (clr_cnt_q == '1) begin
                        state_d   = IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs: grants only in IDLE with enable and no clear start; busy flag mirrors CLEAR.
    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        clr_busy = (state_q == CLEAR);
        if (!rst && state_q == IDLE && bus.en && !bus.clr_start) begin
            if (bus.a_req && bus.b_req) begin
`ifdef MEMARB_FIXED_PRIO_EN
                a_gnt = 1'b1;
`else
                a_gnt = last_winner_q;
                b_gnt = !last_winner_q;
`endif
            end else begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req;
            end
        end
    end

    // Datapath next values: memory issue, round-robin pointer, read tag pipeline and return capture.
    always_comb begin
        mem_cs_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_din_d     = '0;
        last_winner_d = last_winner_q;
        rd_push       = 1'b0;
        if (a_gnt) begin
            mem_cs_d      = 1'b1;
            mem_we_d      = bus.a_we;
            mem_addr_d    = bus.a_addr;
            mem_din_d     = bus.a_wdata;
            last_winner_d = 1'b0;
            rd_push       = !bus.a_we;
        end else if (b_gnt) begin
            mem_cs_d      = 1'b1;
            mem_we_d      = bus.b_we;
            mem_addr_d    = bus.b_addr;
            mem_din_d     = bus.b_wdata;
            last_winner_d = 1'b1;
            rd_push       = !bus.b_we;
        end else if (state_q == CLEAR && bus.en) begin
            mem_cs_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = clr_cnt_q;
            mem_din_d  = '0;
        end
        tag_valid_d = {tag_valid_q[RD_LAT-1:0], rd_push};
        tag_owner_d = {tag_owner_q[RD_LAT-1:0], b_gnt};
        a_rvalid_d  = tag_valid_q[RD_LAT] && !tag_owner_q[RD_LAT];
        b_rvalid_d  = tag_valid_q[RD_LAT] && tag_owner_q[RD_LAT];
        a_rdata_d   = a_rvalid_d ? bus.mem_dout : a_rdata_q;
        b_rdata_d   = b_rvalid_d ? bus.mem_dout : b_rdata_q;
    end

    // Datapath registers: reset clears the issue stage, the tag pipeline and the return ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            last_winner_q <= 1'b1;
            tag_valid_q   <= '0;
            tag_owner_q   <= '0;
            a_rvalid_q    <= 1'b0;
            a_rdata_q     <= '0;
            b_rvalid_q    <= 1'b0;
            b_rdata_q     <= '0;
        end else begin
            mem_cs_q      <= mem_cs_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            last_winner_q <= last_winner_d;
            tag_valid_q   <= tag_valid_d;
            tag_owner_q   <= tag_owner_d;
            a_rvalid_q    <= a_rvalid_d;
            a_rdata_q     <= a_rdata_d;
            b_rvalid_q    <= b_rvalid_d;
            b_rdata_q     <= b_rdata_d;
        end
    end

    assign bus.clr_busy = clr_busy;
    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.mem_cs   = mem_cs_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port coefficient/scratch memory (6-bit address, 14-bit data) between two requesters.
- Requester A is the dsp engine port; requester B is the pixel/config side port.
- Round-robin arbitration with one access issued per cycle and tagged read-data return routing.
- Includes a built-in clear sequencer that zero-fills the whole memory on command.

Parameters:
- AW, 6, memory address width; depth is 2**AW.
- DW, 14, memory data width.
- RD_LAT, 1, memory read latency in cycles from mem_cs to valid mem_dout; legal range 1..3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- en  in  1  global enable; 0 blocks new grants and clear writes, while in-flight reads still return.
- clr_start  in  1  single-cycle pulse that starts a memory zero-fill.
- clr_busy  out  1  high while a clear is in progress.
- a_req  in  1  requester A access request.
- a_we  in  1  A write (1) or read (0).
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  A accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered).
- a_rdata  out  DW  A read data (registered).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A set, for requester B.
- mem_cs  out  1  memory select (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  AW  memory address (registered).
- mem_din  out  DW  memory write data (registered).
- mem_dout  in  DW  memory read data, valid RD_LAT cycles after mem_cs.

Behaviour:
- Reset values:
  - All registered outputs are 0 and the FSM is in IDLE.
  - clr_busy is 0.
  - The round-robin pointer is last_winner = B, so A wins the first contention.
  - The read tag pipeline is cleared.
  - Gnts are 0 while rst is high.
- FSM has two states, IDLE and CLEAR.
- IDLE grant rules:
  - With en=1 and clr_start=0, at most one gnt is high per cycle.
  - Only A requesting: a_gnt=1. Only B requesting: b_gnt=1.
  - Both requesting: grant the requester that is not last_winner.
  - last_winner updates on every grant.
- Handshake:
  - A transfer occurs when req & gnt in the same cycle.
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - Back-to-back grants to the same requester are allowed when it alone requests.
- Issue timing: a transfer in cycle t drives mem_cs=1 and mem_we/addr/din from the granted requester in cycle t+1. mem_cs=0 otherwise.
- Read return:
  - A read transfer in cycle t pushes a tag (valid, owner) into an RD_LAT+1 deep shift pipeline.
  - In cycle t+2+RD_LAT the owner's rvalid=1 for exactly one cycle, and its rdata equals mem_dout captured at t+1+RD_LAT.
  - The non-owner's rvalid stays 0.
  - rdata holds its last value when rvalid=0.
- Writes produce no rvalid.
- Entering CLEAR:
  - clr_start=1 in IDLE: gnts are forced 0 that cycle and the FSM goes to CLEAR.
  - clr_busy=1 from cycle t+1.
- CLEAR behaviour:
  - Each cycle with en=1, write 0 to address counter c, i.e. mem_cs=1, mem_we=1, mem_addr=c, mem_din=0 on the following cycle.
  - c runs 0..2**AW-1 with no wrap.
  - en=0 pauses the counter.
  - After the address 2**AW-1 write is issued, the FSM returns to IDLE and clr_busy falls on the same edge.
  - For AW=6 with en held high: 64 writes, and clr_busy high for 64 cycles.
  - clr_start during CLEAR is ignored. Gnts are 0 throughout CLEAR.
- Reads issued before clr_start still return normally, because the tag pipeline is independent of the FSM.
- rst mid-operation: rst during CLEAR or with reads in flight aborts everything, and no rvalid is produced for dropped reads.
- Simultaneous events: a clr_start in the same cycle as both reqs results in no grant, and both requesters keep waiting.

Optional Feature:
- MEMARB_FIXED_PRIO_EN defined: fixed priority, A always wins contention; last_winner is unused.
- MEMARB_FIXED_PRIO_EN undefined: round-robin as described above.

Test Plan:
- Reset, then a_req=1 read at addr 5 with RD_LAT=1 and mem model returning 14'h1234 -> a_gnt in cycle t, mem_cs/addr=5 at t+1, a_rvalid=1 with a_rdata=14'h1234 at t+3, b_rvalid stays 0.
- a_req and b_req both held high for 6 cycles -> grants alternate A,B,A,B,A,B; with MEMARB_FIXED_PRIO_EN: A on all 6 cycles, b_gnt never 1.
- Write via B (addr 9, data 14'h0ABC), then read via A addr 9 -> mem_we=1 din=14'h0ABC issued once; A read returns 14'h0ABC.
- clr_start pulse with en=1 -> clr_busy high for exactly 64 cycles; 64 writes addr 0..63, data 0; a_req during clear gets no gnt until the cycle after clr_busy falls.
- en=0 for 3 cycles mid-clear -> counter pauses, mem_cs=0 for those cycles, total writes still 64 with no duplicates; en=0 in IDLE with reqs high -> no gnt.
- rst asserted two cycles after a read grant (RD_LAT=2) -> no rvalid ever appears for that read; all outputs 0 next cycle.
